pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 104, width of the generic payload bundle (control and data fields).
REQ-002 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-003 SHALL use reset rst, asynchronous, active-high, and clock clk; all state SHALL be clocked on the rising edge of clk.
REQ-004 Ports, in order (clock and reset first):
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  in_valid  in  1  upstream beat valid
  in_ready  out  1  stage can accept a beat
  in_data  in  DATA_W  upstream payload
  in_pc  in  32  upstream PC
  flush  in  1  synchronous kill of all held beats
  out_valid  out  1  downstream beat valid (the have-inst flag)
  out_ready  in  1  downstream accepts the beat
  out_data  out  DATA_W  held payload
  out_pc  out  32  held PC
  out_pc4  out  32  held PC+4
  bubble_cnt  out  CNT_W  count of downstream-starved cycles

Function
REQ-005 Handshakes: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready; both are sampled at the rising clk edge.
REQ-006 Storage: one main entry drives the outputs and one skid entry holds a beat; each entry holds {data, pc, pc4}.
REQ-007 State machine SHALL have states EMPTY (no entries), BUSY (main only) and FULL (main + skid).
REQ-008 in_ready SHALL be 1 in EMPTY and BUSY and 0 in FULL; in_ready SHALL be decoded from registered state only and SHALL have no combinational path from out_ready.
REQ-009 out_valid SHALL be 1 in BUSY and FULL and 0 in EMPTY.
REQ-010 EMPTY transitions: in_valid -> BUSY, with main loaded from the input; otherwise stay in EMPTY.
REQ-011 BUSY transitions:
  - in_valid & out_ready -> BUSY, main loaded from the input.
  - in_valid & !out_ready -> FULL, skid loaded from the input and main held.
  - !in_valid & out_ready -> EMPTY.
  - otherwise hold.
REQ-012 FULL transitions: out_ready -> BUSY, main loaded from skid; otherwise hold. The input is ignored because in_ready=0.
REQ-013 Latency: an accepted beat SHALL appear on out_* in the next cycle when the stage is EMPTY, or BUSY with out_ready=1; ordering SHALL be strictly FIFO and no beat SHALL be lost or duplicated.
REQ-014 pc4 SHALL be computed as in_pc + 32'h4 (mod 2^32) when a beat is accepted and stored with the beat; 32'hFFFFFFFC SHALL give out_pc4 = 32'h00000000.
REQ-015 Flush SHALL have the highest priority: the next state SHALL be EMPTY in every state, and any beat transferred on the input in the flush cycle SHALL be discarded.
REQ-016 Flush data: data, pc and pc4 registers SHALL hold their values on flush; only the valid state SHALL be cleared.
REQ-017 Output hold: while out_valid=1 and out_ready=0, out_data, out_pc and out_pc4 SHALL be stable.
REQ-018 bubble_cnt SHALL increment by 1 in each cycle with out_ready=1 and out_valid=0, SHALL saturate at 2^CNT_W-1, and SHALL be unaffected by flush.

Reset
REQ-019 rst SHALL force state EMPTY, giving in_ready=1 and out_valid=0.
REQ-020 rst SHALL clear out_data, out_pc and out_pc4 to 0, the skid entry to 0, and bubble_cnt to 0.
REQ-021 Reset mid-operation SHALL discard both entries immediately (asynchronously); the first input transfer after rst deasserts SHALL behave as in EMPTY.

Verification
REQ-022 Pass-through: out_ready=1, 4 consecutive beats with pc 0x100, 0x104, 0x108, 0x10C -> the same beats appear on out_pc with 1-cycle latency, out_pc4 = pc+4, in_ready constantly 1.
REQ-023 Skid: in BUSY holding pc 0x200, out_ready=0 and a beat with pc 0x204 -> state FULL and in_ready=0; out_ready=1 -> 0x200 then 0x204 delivered; in_ready returns to 1 one cycle after the first drain.
REQ-024 Flush in FULL with a simultaneous in_valid -> next cycle out_valid=0 and in_ready=1, and no beat is delivered afterward.
REQ-025 PC wrap: in_pc = 0xFFFFFFFC -> out_pc4 = 0x00000000.
REQ-026 Bubble saturation with CNT_W=4: out_ready=1 and no input for 20 cycles -> bubble_cnt = 15; a flush leaves it at 15; rst -> 0.
REQ-027 Async reset: assert rst between clock edges while in FULL -> in the same cycle out_valid=0, in_ready=1, out_pc=0.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid pipeline register with registered in_ready, flush and bubble counter
module pipe_skid_reg #(
  parameter int DATA_W = 104,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc4,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_data;
  logic [31:0]       skid_pc;
  logic [31:0]       skid_pc4;
  logic [31:0]       in_pc4;

  assign in_pc4 = in_pc + 32'h4;

  // Handshake flags come straight from the state register, so in_ready never sees out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      out_pc    <= '0;
      out_pc4   <= '0;
      skid_data <= '0;
      skid_pc   <= '0;
      skid_pc4  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state    <= BUSY;
            out_data <= in_data;
            out_pc   <= in_pc;
            out_pc4  <= in_pc4;
          end
        end
        BUSY: begin
          if (in_valid && out_ready) begin
            out_data <= in_data;
            out_pc   <= in_pc;
            out_pc4  <= in_pc4;
          end else if (in_valid) begin
            state     <= FULL;
            skid_data <= in_data;
            skid_pc   <= in_pc;
            skid_pc4  <= in_pc4;
          end else if (out_ready) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            state    <= BUSY;
            out_data <= skid_data;
            out_pc   <= skid_pc;
            out_pc4  <= skid_pc4;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Counts cycles where downstream was ready but had nothing to take; flush does not touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (out_ready && (state == EMPTY) && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard bench for pipe_skid_reg
module tb_pipe_skid_reg;
  localparam int DATA_W = 104;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [31:0]       in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc4;
  logic [CNT_W-1:0]  bubble_cnt;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [31:0]       pc;
    logic [31:0]       pc4;
  } ent_t;

  ent_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_bub  = 0;

  pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pc(out_pc), .out_pc4(out_pc4), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with inputs applied; checks, updates the model, advances one cycle.
  task automatic cycle();
    int   occ;
    ent_t e;
    occ = q.size();
    chk("out_valid", 128'(out_valid), 128'(occ != 0));
    chk("in_ready", 128'(in_ready), 128'(occ < 2));
    chk("bubble_cnt", 128'(bubble_cnt), 128'(exp_bub));
    if (occ != 0) begin
      chk("out_data", 128'(out_data), 128'(q[0].d));
      chk("out_pc", 128'(out_pc), 128'(q[0].pc));
      chk("out_pc4", 128'(out_pc4), 128'(q[0].pc4));
    end
    if (out_ready && occ == 0 && exp_bub != 15) exp_bub++;
    if (flush) begin
      q.delete();
    end else begin
      if (out_ready && occ != 0) void'(q.pop_front());
      if (in_valid && occ < 2) begin
        e.d   = in_data;
        e.pc  = in_pc;
        e.pc4 = in_pc + 32'h4;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid  = v;
    in_pc     = pc;
    in_data   = {8'(pc[7:0]), 32'($urandom), 32'($urandom), 32'($urandom)};
    out_ready = ordy;
    flush     = fl;
    cycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_pc", 128'(out_pc), 128'(0));
    chk("rst_out_pc4", 128'(out_pc4), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_bubble", 128'(bubble_cnt), 128'(0));

    // pass-through
    drive(1, 32'h100, 1, 0);
    drive(1, 32'h104, 1, 0);
    drive(1, 32'h108, 1, 0);
    drive(1, 32'h10C, 1, 0);
    chk("pt_last_pc", 128'(out_pc), 128'(32'h10C));
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);

    // skid fill and drain; 0x208 arrives while FULL and must be ignored
    drive(1, 32'h200, 1, 0);
    drive(1, 32'h204, 0, 0);
    chk("skid_in_ready", 128'(in_ready), 128'(0));
    drive(0, 0, 0, 0);
    drive(1, 32'h208, 1, 0);
    chk("skid_second_pc", 128'(out_pc), 128'(32'h204));
    chk("skid_ready_back", 128'(in_ready), 128'(1));
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);

    // flush while FULL with a beat offered, then flush in BUSY
    drive(1, 32'h300, 0, 0);
    drive(1, 32'h304, 0, 0);
    drive(1, 32'h308, 0, 1);
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(1, 32'h400, 1, 0);
    drive(1, 32'h404, 1, 1);
    drive(0, 0, 1, 0);

    // pc wrap
    drive(1, 32'hFFFF_FFFC, 1, 0);
    chk("wrap_pc4", 128'(out_pc4), 128'(0));
    drive(0, 0, 1, 0);

    // random traffic with occasional flush
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);

    // bubble saturation, flush leaves it alone
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0);
    chk("bubble_sat", 128'(bubble_cnt), 128'(15));
    drive(0, 0, 1, 1);
    chk("bubble_flush", 128'(bubble_cnt), 128'(15));

    // asynchronous reset while FULL
    drive(1, 32'h500, 0, 0);
    drive(1, 32'h504, 0, 0);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(1));
    chk("arst_out_pc", 128'(out_pc), 128'(0));
    chk("arst_bubble", 128'(bubble_cnt), 128'(0));
    q.delete();
    exp_bub = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 32'h600, 0, 0);
    chk("post_rst_pc", 128'(out_pc), 128'(32'h600));
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("drained", 128'(q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
